// File: rtl/ddr_cmd_pkg.sv
// Shared DDR command definitions: {RAS,CAS,WE} encodings, address widths and
// the read-sequencer state type.
package ddr_cmd_pkg;

   localparam int ROW_W = 13;
   localparam int COL_W = 10;
   localparam int BA_W  = 2;

   localparam logic [2:0] CMD_NOP       = 3'b111;
   localparam logic [2:0] CMD_ACTIVE    = 3'b011;
   localparam logic [2:0] CMD_READ      = 3'b101;
   localparam logic [2:0] CMD_PRECHARGE = 3'b010;
   localparam logic [2:0] CMD_WRITE     = 3'b100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACT,
      ST_RCD,
      ST_RD,
      ST_CAP,
      ST_RP
   } rdseq_state_t;

   // READ address: A10 set selects auto-precharge, upper row bits unused.
   function automatic logic [ROW_W-1:0] read_addr(input logic [COL_W-1:0] col);
      return {2'b00, 1'b1, col};
   endfunction

endpackage

// File: rtl/ddr_wait_counter.sv
// Loadable 4-bit down-counter with a zero flag; saturates at zero rather than
// wrapping. Shared by the tRCD, CAS-latency and tRP waits.
module ddr_wait_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign zero = (count == 4'd0);

endmodule

// File: rtl/ddr_read_sequencer.sv
// One DDR read per request: ACTIVE, tRCD, READ with auto-precharge, CAS
// latency, burst capture from the PHY, tRP recovery. All outputs registered.
module ddr_read_sequencer
   import ddr_cmd_pkg::*;
#(
   parameter int T_RCD = 3,
   parameter int CL    = 2,
   parameter int BL    = 4,
   parameter int T_RP  = 3,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [BA_W-1:0]  req_bank,
   input  logic [ROW_W-1:0] req_row,
   input  logic [COL_W-1:0] req_col,
   output logic             cke,
   output logic             ras,
   output logic             cas,
   output logic             we,
   output logic [BA_W-1:0]  ba,
   output logic [ROW_W-1:0] addr,
   input  logic [DW-1:0]    dq_in,
   output logic             rd_valid,
   output logic [DW-1:0]    rd_data,
   output logic             rd_last
);

   rdseq_state_t     state, state_d;
   logic             ready_q, ready_d;
   logic [2:0]       cmd_d;
   logic [BA_W-1:0]  ba_d, bank_q;
   logic [ROW_W-1:0] addr_d;
   logic [COL_W-1:0] col_q;
   logic             rd_valid_d, rd_last_d;
   logic [DW-1:0]    rd_data_d;
   logic [3:0]       beat_q, beat_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [3:0]       cnt_val;
   logic             accept;

   assign accept = (state == ST_IDLE) && req_valid;

   // Gated so a requester never sees ready while reset is being applied.
   assign req_ready = ready_q & ~rst;

   ddr_wait_counter u_wait (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // The counter is loaded on the edge entering each wait so that its zero
   // flag lines up with the registered command outputs: T_RCD-1 entering ACT,
   // CL entering RD, T_RP-1 entering RP.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned and infers a latch.
      state_d    = state;
      ready_d    = 1'b0;
      cmd_d      = CMD_NOP;
      ba_d       = ba;
      addr_d     = addr;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data;
      rd_last_d  = 1'b0;
      beat_d     = beat_q;
      cnt_load   = 1'b0;
      cnt_val    = 4'd0;
      cnt_dec    = 1'b0;

      unique case (state)
         ST_IDLE: begin
            if (req_valid) begin
               state_d  = ST_ACT;
               cmd_d    = CMD_ACTIVE;
               ba_d     = req_bank;
               addr_d   = req_row;
               cnt_load = 1'b1;
               cnt_val  = 4'(T_RCD - 1);
            end else begin
               ready_d = 1'b1;
            end
         end
         ST_ACT, ST_RCD: begin
            if (cnt_zero) begin
               state_d  = ST_RD;
               cmd_d    = CMD_READ;
               ba_d     = bank_q;
               addr_d   = read_addr(col_q);
               cnt_load = 1'b1;
               cnt_val  = 4'(CL);
            end else begin
               state_d = ST_RCD;
               cnt_dec = 1'b1;
            end
         end
         ST_RD: begin
            state_d = ST_CAP;
            cnt_dec = 1'b1;
         end
         ST_CAP: begin
            if (cnt_zero) begin
               rd_valid_d = 1'b1;
               rd_data_d  = dq_in;
               beat_d     = beat_q + 4'd1;
               if (beat_q == 4'(BL - 1)) begin
                  rd_last_d = 1'b1;
                  beat_d    = 4'd0;
                  state_d   = ST_RP;
                  cnt_load  = 1'b1;
                  cnt_val   = 4'(T_RP - 1);
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_RP: begin
            if (cnt_zero) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state          <= ST_IDLE;
         ready_q        <= 1'b1;
         cke            <= 1'b1;
         {ras, cas, we} <= CMD_NOP;
         ba             <= '0;
         addr           <= '0;
         rd_valid       <= 1'b0;
         rd_data        <= '0;
         rd_last        <= 1'b0;
         beat_q         <= 4'd0;
         bank_q         <= '0;
         col_q          <= '0;
      end else begin
         state          <= state_d;
         ready_q        <= ready_d;
         cke            <= 1'b1;
         {ras, cas, we} <= cmd_d;
         ba             <= ba_d;
         addr           <= addr_d;
         rd_valid       <= rd_valid_d;
         rd_data        <= rd_data_d;
         rd_last        <= rd_last_d;
         beat_q         <= beat_d;
         if (accept) begin
            bank_q <= req_bank;
            col_q  <= req_col;
         end
      end
   end

endmodule

// File: tb/tb_ddr_read_sequencer.sv
// Scoreboard bench for ddr_read_sequencer in two timing configurations
// (defaults and all-minimum); expectations come from the cycle-level timing rules.
module tb_ddr_read_sequencer;
   import ddr_cmd_pkg::*;

   localparam int DW = 32;

   typedef struct {
      int          cyc;
      logic [2:0]  cmd;
      logic [1:0]  ba;
      logic [12:0] addr;
   } cmd_exp_t;

   typedef struct {
      int          cyc;
      logic [DW-1:0] data;
      logic        last;
   } rd_exp_t;

   typedef struct {
      logic [1:0]  bank;
      logic [12:0] row;
      logic [9:0]  col;
      bit          fixed;
   } req_t;

   logic clk = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input int c, input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL cfg%0d %s at cycle %0d: got %0h want %0h", c, name, cyc, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : cfg
      localparam int TRCD    = (g == 0) ? 3 : 1;
      localparam int TCL     = (g == 0) ? 2 : 1;
      localparam int TBL     = (g == 0) ? 4 : 1;
      localparam int TRP     = (g == 0) ? 3 : 1;
      localparam int RST_OFF = (g == 0) ? 8 : 3;
      localparam int SPAN    = 1 + TRCD + TCL + TBL + TRP;

      logic          rst, req_valid, req_ready, cke, ras, cas, we, rd_valid, rd_last;
      logic [1:0]    req_bank, ba;
      logic [12:0]   req_row, addr;
      logic [9:0]    req_col;
      logic [DW-1:0] dq_in, rd_data;
      bit            done = 1'b0;

      cmd_exp_t      cmd_q[$];
      rd_exp_t       rd_q[$];
      logic [DW-1:0] dq_sched [int];
      int            busy_from = 0;
      int            busy_to = -1;

      ddr_read_sequencer #(
         .T_RCD (TRCD),
         .CL    (TCL),
         .BL    (TBL),
         .T_RP  (TRP),
         .DW    (DW)
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .req_valid (req_valid),
         .req_ready (req_ready),
         .req_bank  (req_bank),
         .req_row   (req_row),
         .req_col   (req_col),
         .cke       (cke),
         .ras       (ras),
         .cas       (cas),
         .we        (we),
         .ba        (ba),
         .addr      (addr),
         .dq_in     (dq_in),
         .rd_valid  (rd_valid),
         .rd_data   (rd_data),
         .rd_last   (rd_last)
      );

      function automatic bit model_busy(input int k);
         return (k >= busy_from) && (k <= busy_to);
      endfunction

      // Requester, PHY and reference model: inputs change 1 time unit after each rising edge.
      initial begin : stim
         req_t          pend;
         bit            has_pend;
         int            rst_at;
         int            acc;
         logic [DW-1:0] w;
         cmd_exp_t      ce;
         rd_exp_t       re;
         has_pend  = 1'b0;
         rst_at    = -1;
         rst       = 1'b1;
         req_valid = 1'b0;
         req_bank  = '0;
         req_row   = '0;
         req_col   = '0;
         dq_in     = '0;
         pend      = '{2'd0, 13'd0, 10'd0, 1'b0};
         for (int i = 0; i < 640; i++) begin
            @(posedge clk);
            #1;
            rst = (i < 3) || (i == 400) || (i == 401) || (cyc == rst_at);
            if (!has_pend) begin
               if (i == 3) begin
                  pend     = '{2'd2, 13'h1ABC, 10'h155, 1'b1};
                  has_pend = 1'b1;
               end else if ((i >= 30 && i < 100) || i == 130 ||
                            (i >= 160 && i < 600 && $urandom_range(2) == 0)) begin
                  pend     = '{2'($urandom), 13'($urandom), 10'($urandom), 1'b0};
                  has_pend = 1'b1;
               end
            end
            if (i >= 600) has_pend = 1'b0;

            if (model_busy(cyc) || rst) begin
               req_valid = has_pend || ($urandom_range(3) == 0);
               req_bank  = 2'($urandom);
               req_row   = 13'($urandom);
               req_col   = 10'($urandom);
            end else begin
               req_valid = has_pend;
               req_bank  = pend.bank;
               req_row   = pend.row;
               req_col   = pend.col;
            end

            if (req_valid && !rst && !model_busy(cyc)) begin
               acc = cyc;
               ce = '{acc + 1, CMD_ACTIVE, req_bank, req_row};
               cmd_q.push_back(ce);
               ce = '{acc + 1 + TRCD, CMD_READ, req_bank, {2'b00, 1'b1, req_col}};
               cmd_q.push_back(ce);
               for (int b = 0; b < TBL; b++) begin
                  w = pend.fixed ? DW'(32'hA0 + b) : DW'($urandom);
                  dq_sched[acc + 1 + TRCD + TCL + b] = w;
                  re = '{acc + 2 + TRCD + TCL + b, w, (b == TBL - 1)};
                  rd_q.push_back(re);
               end
               busy_from = acc + 1;
               busy_to   = acc + SPAN - 1;
               if (i == 130) rst_at = acc + RST_OFF;
               has_pend = 1'b0;
            end

            if (rst) begin
               while (cmd_q.size() > 0 && cmd_q[$].cyc > cyc) void'(cmd_q.pop_back());
               while (rd_q.size() > 0 && rd_q[$].cyc > cyc) void'(rd_q.pop_back());
               busy_to = cyc;
            end

            dq_in = dq_sched.exists(cyc) ? dq_sched[cyc] : DW'($urandom);
         end
         check(g, "cmd_left_over", 64'(cmd_q.size()), 64'd0);
         check(g, "rd_left_over", 64'(rd_q.size()), 64'd0);
         done = 1'b1;
      end

      // Monitor: compares whatever the DUT presents against the queued expectations.
      logic [1:0]  hold_ba = '0;
      logic [12:0] hold_addr = '0;
      bit          armed = 1'b0;

      always @(negedge clk) begin : mon
         cmd_exp_t ce;
         rd_exp_t  re;
         if (armed && !done) begin
            check(g, "req_ready", req_ready, !rst && !model_busy(cyc));
            check(g, "cke", cke, 1'b1);
            if ({ras, cas, we} != CMD_NOP) begin
               if (cmd_q.size() == 0) begin
                  check(g, "cmd_unexpected", {ras, cas, we}, CMD_NOP);
               end else begin
                  ce = cmd_q.pop_front();
                  check(g, "cmd_cycle", 64'(cyc), 64'(ce.cyc));
                  check(g, "cmd", {ras, cas, we}, ce.cmd);
                  check(g, "ba", ba, ce.ba);
                  check(g, "addr", addr, ce.addr);
                  hold_ba   = ce.ba;
                  hold_addr = ce.addr;
               end
            end else if (cmd_q.size() > 0 && cmd_q[0].cyc <= cyc) begin
               ce = cmd_q.pop_front();
               check(g, "cmd_missing", {ras, cas, we}, ce.cmd);
               hold_ba   = ce.ba;
               hold_addr = ce.addr;
            end else begin
               check(g, "ba_hold", ba, hold_ba);
               check(g, "addr_hold", addr, hold_addr);
            end

            if (rd_valid) begin
               if (rd_q.size() == 0) begin
                  check(g, "rd_unexpected", rd_valid, 1'b0);
               end else begin
                  re = rd_q.pop_front();
                  check(g, "rd_cycle", 64'(cyc), 64'(re.cyc));
                  check(g, "rd_data", rd_data, re.data);
                  check(g, "rd_last", rd_last, re.last);
               end
            end else begin
               check(g, "rd_last_idle", rd_last, 1'b0);
               if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                  re = rd_q.pop_front();
                  check(g, "rd_missing", rd_valid, 1'b1);
               end
            end
         end
         if (rst) begin
            armed     = 1'b1;
            hold_ba   = '0;
            hold_addr = '0;
         end
      end
   end

   initial begin
      for (int t = 0; t < 2000; t++) begin
         @(posedge clk);
         if (cfg[0].done && cfg[1].done) break;
      end
      check(0, "bench_finished", {cfg[0].done, cfg[1].done}, 2'b11);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
